vdcmul_16b_pipe: RTL

VDCMUL_16B_PIPE -- requirements
Module: vdcmul_16b_pipe

---
 rtl/vdcmul_16b_pipe_if.sv | 22 ++
 rtl/vdcmul_16b_pipe.sv | 115 +++++++++++
 2 files changed

// File: rtl/vdcmul_16b_pipe_if.sv
// Handshake and data bundle for the 16x16 pipelined Vedic multiplier.
// The producer and consumer both drive through the master side; the multiplier sits on the slave side.
interface vdcmul_16b_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] prod;
    logic        busy;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, prod, busy
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, prod, busy
    );
endinterface

// File: rtl/vdcmul_16b_pipe.sv
// 16x16 unsigned multiplier built from four 8x8 Vedic (Urdhva Tiryagbhyam) partial products.
// Three-stage pipeline with one global advance: a stalled output freezes every stage.
module vdcmul_16b_pipe (
    input  logic                    clk,
    input  logic                    rst,
    vdcmul_16b_pipe_if.slave        bus
);

    function automatic logic [3:0] vedic2(input logic [1:0] a, input logic [1:0] b);
        logic c1, c2, cy, t;
        logic [3:0] p;
        p[0] = a[0] & b[0];
        c1   = a[1] & b[0];
        c2   = a[0] & b[1];
        p[1] = c1 ^ c2;
        cy   = c1 & c2;
        t    = a[1] & b[1];
        p[2] = t ^ cy;
        p[3] = t & cy;
        return p;
    endfunction

    function automatic logic [7:0] vedic4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] q0, q1, q2, q3;
        logic [4:0] mid;
        q0  = vedic2(a[1:0], b[1:0]);
        q1  = vedic2(a[1:0], b[3:2]);
        q2  = vedic2(a[3:2], b[1:0]);
        q3  = vedic2(a[3:2], b[3:2]);
        mid = {1'b0, q1} + {1'b0, q2};
        return {q3, q0} + {1'b0, mid, 2'b00};
    endfunction

    function automatic logic [15:0] vedic8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q0, q1, q2, q3;
        logic [8:0] mid;
        q0  = vedic4(a[3:0], b[3:0]);
        q1  = vedic4(a[3:0], b[7:4]);
        q2  = vedic4(a[7:4], b[3:0]);
        q3  = vedic4(a[7:4], b[7:4]);
        mid = {1'b0, q1} + {1'b0, q2};
        return {q3, q0} + {3'b000, mid, 4'b0000};
    endfunction

    logic        adv;
    logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [15:0] pp1_q, pp1_d, pp2_q, pp2_d, pp3_q, pp3_d, pp4_q, pp4_d;
    logic [15:0] s2_pp1_q, s2_pp1_d, s2_pp4_q, s2_pp4_d;
    logic [16:0] mid_q, mid_d;
    logic [31:0] prod_q, prod_d;

    assign adv = ~v3_q | bus.out_ready;

    // Pipeline is empty after any reset edge, so accepting during rst is harmless upstream.
    assign bus.in_ready  = adv | rst;
    assign bus.out_valid = v3_q;
    assign bus.prod      = prod_q;
    assign bus.busy      = v1_q | v2_q | v3_q;

    always_comb begin
        v1_d     = v1_q;
        v2_d     = v2_q;
        v3_d     = v3_q;
        pp1_d    = pp1_q;
        pp2_d    = pp2_q;
        pp3_d    = pp3_q;
        pp4_d    = pp4_q;
        mid_d    = mid_q;
        s2_pp1_d = s2_pp1_q;
        s2_pp4_d = s2_pp4_q;
        prod_d   = prod_q;
        if (adv) begin
            v1_d     = bus.in_valid;
            pp1_d    = vedic8(bus.x[7:0],  bus.y[7:0]);
            pp2_d    = vedic8(bus.x[7:0],  bus.y[15:8]);
            pp3_d    = vedic8(bus.x[15:8], bus.y[7:0]);
            pp4_d    = vedic8(bus.x[15:8], bus.y[15:8]);
            v2_d     = v1_q;
            mid_d    = {1'b0, pp2_q} + {1'b0, pp3_q};
            s2_pp1_d = pp1_q;
            s2_pp4_d = pp4_q;
            v3_d     = v2_q;
            prod_d   = {s2_pp4_q, 16'h0000} + {7'b0, mid_q, 8'h00} + {16'h0000, s2_pp1_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            pp1_q    <= '0;
            pp2_q    <= '0;
            pp3_q    <= '0;
            pp4_q    <= '0;
            mid_q    <= '0;
            s2_pp1_q <= '0;
            s2_pp4_q <= '0;
            prod_q   <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            pp1_q    <= pp1_d;
            pp2_q    <= pp2_d;
            pp3_q    <= pp3_d;
            pp4_q    <= pp4_d;
            mid_q    <= mid_d;
            s2_pp1_q <= s2_pp1_d;
            s2_pp4_q <= s2_pp4_d;
            prod_q   <= prod_d;
        end
    end

endmodule
